acq_sched: RTL and testbench
============================

ACQ_SCHED -- requirements
Module: acq_sched

Interface
REQ-001 Parameter: DW, 12, ADC sample width per channel.
REQ-002 Parameter: TIMEOUT, 255, maximum clk cycles from adc_start to adc_done.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 scan_en  in  1  enables the periodic scan timer.
REQ-006 latch_period  in  1  one-cycle strobe that loads period_word.
REQ-007 period_word  in  16  scan period in clk cycles, minus 1.
REQ-008 ch_mask  in  3  per-channel enable for ADC ports 0..2.
REQ-009 adc_start  out  3  one-hot, one-cycle conversion start pulse per channel.
REQ-010 adc_busy  in  3  per-channel converter busy.
REQ-011 adc_done  in  3  per-channel one-cycle result strobe.
REQ-012 adc_data  in  3*DW  flattened samples; channel n occupies bits [n*DW +: DW].
REQ-013 out_valid  out  1  result word available.
REQ-014 out_ready  in  1  downstream (SSI packer) accepts the word.
REQ-015 out_data  out  16  [15]=first-of-scan, [14:13]=channel, [12]=0, [11:0]=sample.
REQ-016 overrun  out  1  sticky: a scan tick arrived while a scan was still in progress.
REQ-017 ch_timeout  out  3  sticky per-channel timeout flag.
REQ-018 clr_err  in  1  one-cycle strobe that clears overrun and ch_timeout.

Function
REQ-019 Tick generation:
- Period counter counts 0..period_reg while scan_en=1.
- Reaching period_reg produces a one-cycle tick and reloads 0.
- scan_en=0 holds the counter at 0.
- latch_period loads period_reg and zeroes the counter in the same cycle.
- period_reg=0 produces a tick every cycle.
REQ-020 State machine states: IDLE, START, CONV, PUSH.
REQ-021 Scan start:
- A tick in IDLE with ch_mask!=0 samples ch_mask into scan_mask and selects the lowest set channel.
- The FSM then enters START.
- A tick with ch_mask=0 is ignored and does not set overrun.
REQ-022 START:
- Waits while adc_busy[ch]=1.
- Otherwise pulses adc_start[ch] for exactly one cycle and enters CONV.
REQ-023 CONV:
- On adc_done[ch], captures adc_data for channel ch and enters PUSH.
- adc_done on any other channel is ignored.
REQ-024 PUSH:
- Holds out_valid=1 with out_data stable until out_valid&out_ready.
- Then advances to the next higher set bit of scan_mask and enters START.
- Returns to IDLE when no set bit remains.
REQ-025 Bit 15 of out_data is set only on the first word emitted in each scan.
REQ-026 Latency: adc_start follows the START entry cycle; out_valid rises the cycle after adc_done.
REQ-027 A tick outside IDLE sets overrun and is dropped; the scan in progress is unaffected.
REQ-028 Changes to ch_mask or scan_en do not affect a scan already in progress.
REQ-029 If clr_err and a new error event occur in the same cycle, the error event wins.

Reset
REQ-030 rst=0 forces the following immediately, regardless of clk:
- FSM to IDLE;
- counter and period_reg to 0;
- adc_start, out_valid, out_data, overrun and ch_timeout to 0.
REQ-031 Reset applied mid-scan abandons the scan; no word is emitted after release until the next tick.

Configuration
REQ-032 Macro ACQ_SCHED_TIMEOUT_EN, when defined: in CONV, if adc_done is absent for TIMEOUT cycles after adc_start, then:
- ch_timeout[ch] is set;
- no word is emitted for that channel;
- the FSM advances as if PUSH had completed.
REQ-033 Without ACQ_SCHED_TIMEOUT_EN, CONV waits indefinitely and ch_timeout is constant 0.

Structure
REQ-034 Shared package acq_sched_pkg holds the following, for reuse by the SSI packer:
- state enum;
- NCH=3;
- out_data field positions.
REQ-035 One sub-module, acq_tick_gen, contains the period counter, period_reg and tick output.

Verification
REQ-036 period_word=9 latched, scan_en=1, ch_mask=3'b101, out_ready=1, adc_done 4 cycles after each start:
- ticks every 10 cycles;
- words ch0 then ch2, with bit15 set only on the ch0 word.
REQ-037 out_ready=0 for 20 cycles during PUSH: out_valid and out_data stay stable; no adc_start is issued until the handshake completes.
REQ-038 period_word=3, conversions take 8 cycles: overrun=1 after the first scan; clr_err clears it; the scan sequence stays intact.
REQ-039 adc_busy[1]=1 for 15 cycles at the ch1 START: adc_start[1] pulses in the cycle after busy falls.
REQ-040 ACQ_SCHED_TIMEOUT_EN defined, TIMEOUT=255, ch1 never done:
- ch_timeout=3'b010 at cycle 255 after the start;
- ch2 word follows;
- no ch1 word is emitted.
REQ-041 rst asserted during CONV of ch0: outputs reach reset values immediately; after release, no word is emitted before the next tick.

Source files
------------

// File: rtl/acq_sched_pkg.sv
// Shared types and field layout for the ADC acquisition scheduler and the SSI packer.
package acq_sched_pkg;

  localparam int unsigned NCH      = 3;
  localparam int unsigned CHW      = 2;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned SAMPLE_W = 12;

  // out_data field positions
  localparam int unsigned OUT_FIRST_BIT  = 15;
  localparam int unsigned OUT_CH_MSB     = 14;
  localparam int unsigned OUT_CH_LSB     = 13;
  localparam int unsigned OUT_RSVD_BIT   = 12;
  localparam int unsigned OUT_SAMPLE_MSB = 11;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StConv,
    StPush
  } acq_state_e;

  typedef struct packed {
    logic           found;
    logic [CHW-1:0] idx;
  } ch_sel_t;

  // Lowest set bit of mask at or above min_idx.
  function automatic ch_sel_t pick_ch(input logic [NCH-1:0] mask, input logic [CHW-1:0] min_idx);
    ch_sel_t sel;
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[CHW'(i)] && (i >= int'(min_idx))) begin
        sel.found = 1'b1;
        sel.idx   = CHW'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic [OUT_W-1:0] pack_word(input logic first, input logic [CHW-1:0] ch,
                                                 input logic [SAMPLE_W-1:0] sample);
    return {first, ch, 1'b0, sample};
  endfunction

endpackage

// File: rtl/acq_tick_gen.sv
// Scan period timer: counts 0..period_reg and emits a one-cycle tick on reaching period_reg.
module acq_tick_gen
  import acq_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic                latch_period,
  input  logic [PERIOD_W-1:0] period_word,
  output logic                tick
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                at_end;

  assign at_end = (cnt_q == period_q);

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (latch_period || !scan_en || at_end) begin
      cnt_d = '0;
    end
  end

  // The latch cycle restarts the period, so it never ticks itself.
  assign tick = scan_en && at_end && !latch_period;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (latch_period) begin
        period_q <= period_word;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acq_sched.sv
// Periodic multi-channel ADC scan scheduler feeding a valid/ready result stream.
// Optional conversion timeout is enabled by defining ACQ_SCHED_TIMEOUT_EN.
module acq_sched
  import acq_sched_pkg::*;
#(
  parameter int unsigned DW      = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic                latch_period,
  input  logic [PERIOD_W-1:0] period_word,
  input  logic [NCH-1:0]      ch_mask,
  output logic [NCH-1:0]      adc_start,
  input  logic [NCH-1:0]      adc_busy,
  input  logic [NCH-1:0]      adc_done,
  input  logic [NCH*DW-1:0]   adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                overrun,
  output logic [NCH-1:0]      ch_timeout,
  input  logic                clr_err
);

  acq_state_e          state_q, state_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic                first_q, first_d;
  logic [OUT_W-1:0]    word_q, word_d;
  logic [NCH-1:0]      start_q, start_d;
  logic                overrun_q, overrun_d;
  logic                tick;
  logic                timeout_hit;
  ch_sel_t             sel_first, sel_next;
  acq_state_e          adv_state;
  logic [CHW-1:0]      adv_ch;
  logic [DW-1:0]       sel_data;
  logic [SAMPLE_W-1:0] sample;

  acq_tick_gen u_tick_gen (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en),
    .latch_period (latch_period),
    .period_word  (period_word),
    .tick         (tick)
  );

  assign sel_first = pick_ch(ch_mask, '0);
  assign sel_next  = pick_ch(mask_q, ch_q + 2'd1);
  assign adv_state = sel_next.found ? StStart : StIdle;
  assign adv_ch    = sel_next.found ? sel_next.idx : ch_q;
  assign sel_data  = adc_data[ch_q*DW +: DW];
  assign sample    = SAMPLE_W'(sel_data);

`ifdef ACQ_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]  tmr_q, tmr_d;
  logic [NCH-1:0] chto_q, chto_d;

  // Timer is 0 in the first CONV cycle, i.e. the cycle adc_start is visible.
  assign timeout_hit = (state_q == StConv) && !adc_done[ch_q] && (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmr_d  = tmr_q;
    chto_d = chto_q;
    if (state_q == StStart) begin
      tmr_d = '0;
    end else if (state_q == StConv) begin
      tmr_d = tmr_q + TW'(1);
    end
    if (clr_err) begin
      chto_d = '0;
    end
    if (timeout_hit) begin
      chto_d[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q  <= '0;
      chto_q <= '0;
    end else begin
      tmr_q  <= tmr_d;
      chto_q <= chto_d;
    end
  end

  assign ch_timeout = chto_q;
`else
  assign timeout_hit = 1'b0;
  assign ch_timeout  = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      mask_q    <= '0;
      first_q   <= 1'b0;
      word_q    <= '0;
      start_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      first_q   <= first_d;
      word_q    <= word_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    first_d   = first_q;
    word_d    = word_q;
    start_d   = '0;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (tick && sel_first.found) begin
          mask_d  = ch_mask;
          ch_d    = sel_first.idx;
          first_d = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!adc_busy[ch_q]) begin
          start_d = NCH'(1) << ch_q;
          state_d = StConv;
        end
      end
      StConv: begin
        if (adc_done[ch_q]) begin
          word_d  = pack_word(first_q, ch_q, sample);
          state_d = StPush;
        end else if (timeout_hit) begin
          // Timed-out channel emits nothing, so first-of-scan stays pending.
          ch_d    = adv_ch;
          state_d = adv_state;
        end
      end
      StPush: begin
        if (out_ready) begin
          first_d = 1'b0;
          ch_d    = adv_ch;
          state_d = adv_state;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new error event overrides a simultaneous clear.
    if (clr_err) begin
      overrun_d = 1'b0;
    end
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    out_valid = (state_q == StPush);
    out_data  = word_q;
    adc_start = start_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_acq_sched.sv
// Directed self-checking bench for acq_sched; timeout scenario runs when ACQ_SCHED_TIMEOUT_EN is set.
module tb_acq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en, latch_period, clr_err, out_ready;
  logic [15:0] period_word;
  logic [2:0]  ch_mask, adc_busy, adc_done, adc_start, ch_timeout;
  logic [35:0] adc_data;
  logic        out_valid, overrun;
  logic [15:0] out_data;

  int          checks = 0;
  int          errors = 0;
  int          done_delay = 4;
  logic [2:0]  never_done = 3'b000;

  assign adc_data = {12'h789, 12'h456, 12'h123};

  always #5 clk = ~clk;

  acq_sched #(
    .DW      (12),
    .TIMEOUT (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en),
    .latch_period (latch_period),
    .period_word  (period_word),
    .ch_mask      (ch_mask),
    .adc_start    (adc_start),
    .adc_busy     (adc_busy),
    .adc_done     (adc_done),
    .adc_data     (adc_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overrun      (overrun),
    .ch_timeout   (ch_timeout),
    .clr_err      (clr_err)
  );

  // ADC model: answers each start with a done pulse done_delay cycles later.
  initial begin
    int pend[3];
    for (int i = 0; i < 3; i++) pend[i] = 0;
    adc_done = '0;
    forever begin
      @(negedge clk);
      adc_done = '0;
      for (int i = 0; i < 3; i++) begin
        if (pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) adc_done[2'(i)] = 1'b1;
        end
        if (adc_start[2'(i)] && !never_done[2'(i)]) pend[i] = done_delay;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiesce;
    scan_en = 0; latch_period = 0; out_ready = 1; adc_busy = '0; ch_mask = '0;
    never_done = '0; done_delay = 4;
    tick_n(40);
    clr_err = 1;
    tick_n(1);
    clr_err = 0;
  endtask

  // Latch is driven at negedge N0; returns at N1.
  task automatic kick(input logic [15:0] pw, input logic [2:0] mask);
    period_word = pw; ch_mask = mask; latch_period = 1; scan_en = 1;
    tick_n(1);
    latch_period = 0;
  endtask

  task automatic wait_start(input logic [1:0] ch, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (adc_start[ch]) n = i;
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL wait_start: no adc_start[%0d] within %0d cycles", ch, budget);
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL wait_valid: no out_valid within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    checks++; if (adc_start !== 3'b000) begin errors++; $display("FAIL rst_start: got %b want 000", adc_start); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++; if (ch_timeout !== 3'b000) begin errors++; $display("FAIL rst_chto: got %b want 000", ch_timeout); end
    rst = 1;
    tick_n(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_tick;
    int n;
    quiesce();
    kick(16'd9, 3'b001);
    wait_start(2'd0, 30, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL tick_first: got %0d want 11", n); end
    wait_start(2'd0, 30, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL tick_period1: got %0d want 10", n); end
    wait_start(2'd0, 30, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL tick_period2: got %0d want 10", n); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL tick_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_scan_order;
    int n;
    quiesce();
    kick(16'd9, 3'b101);
    wait_start(2'd0, 30, n);
    wait_valid(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL order_lat: got %0d want 5", n); end
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL order_w0: got %h want 8123", out_data); end
    wait_valid(20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL order_gap: got %0d want 7", n); end
    checks++; if (out_data !== 16'h4789) begin errors++; $display("FAIL order_w2: got %h want 4789", out_data); end
  endtask

  task automatic test_backpressure;
    int n;
    quiesce();
    out_ready = 0;
    kick(16'd9, 3'b011);
    wait_valid(40, n);
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL bp_w0: got %h want 8123", out_data); end
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL bp_data: got %h want 8123", out_data); end
      checks++; if (adc_start !== 3'b000) begin errors++; $display("FAIL bp_start: got %b want 000", adc_start); end
    end
    out_ready = 1;
    wait_start(2'd1, 10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_next_start: got %0d want 2", n); end
    wait_valid(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL bp_w1_lat: got %0d want 5", n); end
    checks++; if (out_data !== 16'h2456) begin errors++; $display("FAIL bp_w1: got %h want 2456", out_data); end
  endtask

  task automatic test_overrun;
    int n;
    quiesce();
    done_delay = 8;
    kick(16'd3, 3'b001);
    tick_n(6);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", overrun); end
    tick_n(2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    clr_err = 1;
    tick_n(1);
    clr_err = 0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    tick_n(2);
    clr_err = 1;  // coincides with a dropped tick
    tick_n(1);
    clr_err = 0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_event_wins: got %b want 1", overrun); end
    wait_valid(10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL ovr_w_lat: got %0d want 2", n); end
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL ovr_w: got %h want 8123", out_data); end
    wait_start(2'd0, 10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ovr_rescan: got %0d want 3", n); end
    wait_valid(20, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL ovr_w2_lat: got %0d want 9", n); end
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL ovr_w2: got %h want 8123", out_data); end
  endtask

  task automatic test_empty_mask;
    int n;
    logic seen;
    quiesce();
    kick(16'd0, 3'b000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (adc_start !== 3'b000) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL empty_start: got %b want 0", seen); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL empty_overrun: got %b want 0", overrun); end
    ch_mask = 3'b001;
    wait_start(2'd0, 5, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL p0_start: got %0d want 2", n); end
    tick_n(1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL p0_overrun: got %b want 1", overrun); end
  endtask

  task automatic test_busy;
    int n;
    quiesce();
    adc_busy = 3'b010;
    kick(16'd9, 3'b010);
    tick_n(9);
    for (int i = 0; i < 15; i++) begin
      tick_n(1);
      checks++; if (adc_start !== 3'b000) begin errors++; $display("FAIL busy_hold: got %b want 000", adc_start); end
    end
    adc_busy = 3'b000;
    tick_n(1);
    checks++; if (adc_start !== 3'b010) begin errors++; $display("FAIL busy_start: got %b want 010", adc_start); end
    tick_n(1);
    checks++; if (adc_start !== 3'b000) begin errors++; $display("FAIL busy_pulse: got %b want 000", adc_start); end
    wait_valid(10, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL busy_w_lat: got %0d want 4", n); end
    checks++; if (out_data !== 16'hA456) begin errors++; $display("FAIL busy_w: got %h want A456", out_data); end
  endtask

  task automatic test_reset_mid_scan;
    int n;
    logic seen;
    quiesce();
    kick(16'd9, 3'b001);
    wait_start(2'd0, 30, n);
    tick_n(1);
    rst = 0; scan_en = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mrst_data: got %h want 0000", out_data); end
    checks++; if (adc_start !== 3'b000) begin errors++; $display("FAIL mrst_start: got %b want 000", adc_start); end
    checks++; if (ch_timeout !== 3'b000) begin errors++; $display("FAIL mrst_chto: got %b want 000", ch_timeout); end
    tick_n(2);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (out_valid !== 1'b0 || adc_start !== 3'b000) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mrst_quiet: got %b want 0", seen); end
    kick(16'd9, 3'b001);
    wait_valid(30, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL mrst_w_lat: got %0d want 16", n); end
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL mrst_w: got %h want 8123", out_data); end
  endtask

`ifdef ACQ_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    logic seen;
    quiesce();
    never_done = 3'b010;
    kick(16'd9, 3'b111);
    wait_valid(30, n);
    checks++; if (out_data !== 16'h8123) begin errors++; $display("FAIL to_w0: got %h want 8123", out_data); end
    scan_en = 0;
    wait_start(2'd1, 10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL to_start1: got %0d want 2", n); end
    seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick_n(1);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_no_word: got %b want 0", seen); end
    checks++; if (ch_timeout !== 3'b000) begin errors++; $display("FAIL to_early: got %b want 000", ch_timeout); end
    tick_n(1);
    checks++; if (ch_timeout !== 3'b010) begin errors++; $display("FAIL to_flag: got %b want 010", ch_timeout); end
    wait_valid(20, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL to_w2_lat: got %0d want 6", n); end
    checks++; if (out_data !== 16'h4789) begin errors++; $display("FAIL to_w2: got %h want 4789", out_data); end
  endtask
`else
  task automatic test_no_timeout;
    int n;
    quiesce();
    never_done = 3'b010;
    kick(16'd9, 3'b010);
    wait_start(2'd1, 30, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL nto_start: got %0d want 11", n); end
    scan_en = 0;
    tick_n(300);
    checks++; if (ch_timeout !== 3'b000) begin errors++; $display("FAIL nto_flag: got %b want 000", ch_timeout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nto_valid: got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    rst = 0; scan_en = 0; latch_period = 0; clr_err = 0; out_ready = 1;
    period_word = '0; ch_mask = '0; adc_busy = '0;
    tick_n(3);
    test_reset();
    test_tick();
    test_scan_order();
    test_backpressure();
    test_overrun();
    test_empty_mask();
    test_busy();
    test_reset_mid_scan();
`ifdef ACQ_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
